// File: rtl/pipelined_cla_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder_pkg
// Shared constants for the pipelined carry-lookahead adder:
//   DEFAULT_WIDTH - default operand/result width (legal: 8..64, multiple of 8)
//   GROUP_SIZE    - bits per generate/propagate lookahead group
//   alu_op_e      - encoding of the 'sub' operation select
// ---------------------------------------------------------------------------
package pipelined_cla_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int GROUP_SIZE    = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

endpackage : pipelined_cla_adder_pkg

// File: rtl/cla_half_adder_slice.sv
// ---------------------------------------------------------------------------
// cla_half_adder_slice
// Purely combinational carry-lookahead adder over HW bits built from 4-bit
// generate/propagate groups. Inside a group every carry is a flattened
// lookahead expression; the group carries chain group G/P terms.
// Ports:
//   a, b   : HW-bit addends
//   c_in   : carry into bit 0
//   sum    : HW-bit sum
//   c_out  : carry out of bit HW-1
// HW must be a multiple of GROUP_SIZE.
// ---------------------------------------------------------------------------
module cla_half_adder_slice
    import pipelined_cla_adder_pkg::*;
#(
    parameter int HW = DEFAULT_WIDTH / 2
) (
    input  logic [HW-1:0] a,
    input  logic [HW-1:0] b,
    input  logic          c_in,
    output logic [HW-1:0] sum,
    output logic          c_out
);

    localparam int NG = HW / GROUP_SIZE;

    // Carry into each group; c_grp[NG] is the slice carry-out.
    logic [NG:0] c_grp;

    assign c_grp[0] = c_in;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_group
            logic [GROUP_SIZE-1:0] gg;
            logic [GROUP_SIZE-1:0] pp;
            logic [GROUP_SIZE-1:0] cc;
            logic                  grp_g;
            logic                  grp_p;

            assign gg = a[gi*GROUP_SIZE +: GROUP_SIZE] & b[gi*GROUP_SIZE +: GROUP_SIZE];
            assign pp = a[gi*GROUP_SIZE +: GROUP_SIZE] ^ b[gi*GROUP_SIZE +: GROUP_SIZE];

            // Bit carries written as two-level lookahead from the group carry-in.
            assign cc[0] = c_grp[gi];
            assign cc[1] = gg[0] | (pp[0] & c_grp[gi]);
            assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c_grp[gi]);
            assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                         | (pp[2] & pp[1] & pp[0] & c_grp[gi]);

            assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                         | (pp[3] & pp[2] & pp[1] & gg[0]);
            assign grp_p = &pp;

            assign sum[gi*GROUP_SIZE +: GROUP_SIZE] = pp ^ cc;
            assign c_grp[gi+1] = grp_g | (grp_p & c_grp[gi]);
        end
    endgenerate

    assign c_out = c_grp[NG];

endmodule : cla_half_adder_slice

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
// Two-stage pipelined add/subtract with valid/ready handshakes on both sides.
//   Stage 1: low half sum + mid carry (subtract = A + ~B + 1).
//   Stage 2: high half sum from the registered mid carry, plus flags.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake; a, b, sub (0 add, 1 sub)
//   out_valid/out_ready: result handshake
//   sum, c_out, ovf, zero, neg : registered result and flags
// WIDTH: multiple of 8 in 8..64, so each half is a whole number of groups.
// ---------------------------------------------------------------------------
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int HW = WIDTH / 2;

    logic advance1;
    logic advance2;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] b_eff_d;
    logic [HW-1:0]    lo_sum_d;
    logic             mid_c_d;

    logic             s1_valid_q;
    logic [HW-1:0]    s1_lo_sum_q;
    logic             s1_mid_c_q;
    logic [HW-1:0]    s1_a_hi_q;
    logic [HW-1:0]    s1_b_hi_q;

    assign b_eff_d = (sub == OP_SUB) ? ~b : b;

    cla_half_adder_slice #(.HW(HW)) u_lo_slice (
        .a     (a[HW-1:0]),
        .b     (b_eff_d[HW-1:0]),
        .c_in  (sub),
        .sum   (lo_sum_d),
        .c_out (mid_c_d)
    );

    // ---------------- stage 2 ----------------
    logic [HW-1:0]    hi_sum_d;
    logic             c_out_d;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;
    logic             zero_d;
    logic             neg_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    cla_half_adder_slice #(.HW(HW)) u_hi_slice (
        .a     (s1_a_hi_q),
        .b     (s1_b_hi_q),
        .c_in  (s1_mid_c_q),
        .sum   (hi_sum_d),
        .c_out (c_out_d)
    );

    assign sum_d  = {hi_sum_d, s1_lo_sum_q};
    // The registered high halves carry the MSBs of a and b_eff.
    assign ovf_d  = (s1_a_hi_q[HW-1] == s1_b_hi_q[HW-1]) && (hi_sum_d[HW-1] != s1_a_hi_q[HW-1]);
    assign zero_d = (sum_d == '0);
    assign neg_d  = hi_sum_d[HW-1];

    // ---------------- flow control ----------------
    // Stage 2 may load when empty or being drained; stage 1 may load when
    // empty or when its contents move on to stage 2 on the same edge.
    assign advance2 = !out_valid_q || out_ready;
    assign advance1 = !s1_valid_q || advance2;
    assign in_ready = advance1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_lo_sum_q <= '0;
            s1_mid_c_q  <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
        end else if (advance1) begin
            s1_valid_q <= in_valid;
            // Data only loads on a real transfer; a bubble just clears valid.
            if (in_valid) begin
                s1_lo_sum_q <= lo_sum_d;
                s1_mid_c_q  <= mid_c_d;
                s1_a_hi_q   <= a[WIDTH-1:HW];
                s1_b_hi_q   <= b_eff_d[WIDTH-1:HW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (advance2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q   <= sum_d;
                c_out_q <= c_out_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
                neg_q   <= neg_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule : pipelined_cla_adder
